// File: rtl/pdm_cic_decimator_if.sv
`default_nettype none
// ============================================================================
// Module   : pdm_cic_decimator_if
// Purpose  : Bundles the control, microphone and sample-memory write signals
//            of one PDM-to-PCM channel.
// Ports    : Enable, DMDATA        (to decimator)
//            DMCLK                 (mic clock, from decimator)
//            MemWE, MemAddr, MemData, SampleDelayZero (memory write side)
//            DMLocationWritingTo   (next ring location to be written)
//            modport master = decimator side, slave = consumer/driver side.
// Revision : 1.0  initial release
// ============================================================================
interface pdm_cic_decimator_if #(
    parameter int OUT_W  = 9,
    parameter int ADDR_W = 10
);
    logic              Enable;
    logic              DMDATA;
    logic              DMCLK;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [OUT_W-1:0]  MemData;
    logic [ADDR_W-1:0] DMLocationWritingTo;
    logic              SampleDelayZero;

    modport master (
        input  Enable, DMDATA,
        output DMCLK, MemWE, MemAddr, MemData, DMLocationWritingTo, SampleDelayZero
    );

    modport slave (
        output Enable, DMDATA,
        input  DMCLK, MemWE, MemAddr, MemData, DMLocationWritingTo, SampleDelayZero
    );
endinterface
`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_cic_decimator
// Purpose  : Generates the microphone clock, filters the PDM bitstream with a
//            3rd-order CIC decimator and writes saturated signed PCM samples
//            into a circular sample memory.
// Ports    : CLK  - system clock
//            rst  - synchronous active-high reset
//            bus  - pdm_cic_decimator_if.master (Enable, DMDATA, DMCLK,
//                   MemWE, MemAddr, MemData, DMLocationWritingTo,
//                   SampleDelayZero)
// Revision : 1.0  initial release
// ============================================================================
module pdm_cic_decimator #(
    parameter int CLK_DIV = 16,
    parameter int DECIM   = 64,
    parameter int OUT_W   = 9,
    parameter int ADDR_W  = 10
) (
    input  wire logic               CLK,
    input  wire logic               rst,
    pdm_cic_decimator_if.master     bus
);
    localparam int ACC_W = 20;
    localparam int SHIFT = 10;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DEC_W = $clog2(DECIM);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W-1)));

    logic [DIV_W-1:0]        div_cnt;
    logic [DEC_W-1:0]        dec_cnt;
    logic                    dm_meta, dm_sync;
    logic                    tick;
    logic signed [ACC_W-1:0] pdm_val;
    logic signed [ACC_W-1:0] int1, int2, int3;
    logic signed [ACC_W-1:0] dly1, dly2, dly3;
    logic signed [ACC_W-1:0] c1, c2, c3;
    logic                    v1, v2, v3;
    logic signed [ACC_W-1:0] scaled;
    logic [OUT_W-1:0]        sat;
    logic [1:0]              prime_cnt;
    logic                    enable_d;
    logic [ADDR_W-1:0]       wr_ptr;

    // The tick is the last CLK of the DMCLK high phase, so the next edge
    // both samples the bit and drops DMCLK.
    assign tick      = bus.Enable && (div_cnt == DIV_W'(CLK_DIV-1));
    assign bus.DMCLK = (div_cnt >= DIV_W'(CLK_DIV/2));
    assign pdm_val   = dm_sync ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

    assign bus.DMLocationWritingTo = wr_ptr;

    // Front end: divider, synchronizer, integrators, decimator, first comb.
    // The first comb is folded into the decimating tick so the write lands
    // exactly four CLKs after that tick.
    always_ff @(posedge CLK) begin
        if (rst) begin
            div_cnt <= '0;
            dec_cnt <= '0;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
            int1    <= '0;
            int2    <= '0;
            int3    <= '0;
            dly1    <= '0;
            c1      <= '0;
            v1      <= 1'b0;
        end else begin
            dm_meta <= bus.DMDATA;
            dm_sync <= dm_meta;
            v1      <= 1'b0;
            if (!bus.Enable || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
            if (tick) begin
                // Pipelined cascade; modulo-2^20 wrap cancels in the combs.
                int1 <= int1 + pdm_val;
                int2 <= int2 + int1;
                int3 <= int3 + int2;
                if (dec_cnt == DEC_W'(DECIM-1)) begin
                    dec_cnt <= '0;
                    dly1    <= int3;
                    c1      <= int3 - dly1;
                    v1      <= 1'b1;
                end else begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
        end
    end

    // Arithmetic shift, then clamp to the signed output range.
    assign scaled = c3 >>> SHIFT;
    always_comb begin
        sat = scaled[OUT_W-1:0];
        if (scaled > SAT_MAX)
            sat = SAT_MAX[OUT_W-1:0];
        else if (scaled < SAT_MIN)
            sat = SAT_MIN[OUT_W-1:0];
    end

    // Back end: remaining combs, priming, memory write. Runs independently
    // of Enable so a sample already in flight still completes.
    always_ff @(posedge CLK) begin
        if (rst) begin
            dly2                <= '0;
            dly3                <= '0;
            c2                  <= '0;
            c3                  <= '0;
            v2                  <= 1'b0;
            v3                  <= 1'b0;
            prime_cnt           <= '0;
            enable_d            <= 1'b0;
            wr_ptr              <= '0;
            bus.MemWE           <= 1'b0;
            bus.MemAddr         <= '0;
            bus.MemData         <= '0;
            bus.SampleDelayZero <= 1'b0;
        end else begin
            enable_d            <= bus.Enable;
            v2                  <= v1;
            v3                  <= v2;
            bus.MemWE           <= 1'b0;
            bus.SampleDelayZero <= 1'b0;
            if (v1) begin
                dly2 <= c1;
                c2   <= c1 - dly2;
            end
            if (v2) begin
                dly3 <= c2;
                c3   <= c2 - dly3;
            end
            if (bus.MemWE)
                wr_ptr <= wr_ptr + 1'b1;
            // The first three outputs still carry stale comb/integrator
            // history, so they are consumed without a write.
            if (v3) begin
                if (prime_cnt == 2'd3) begin
                    bus.MemWE           <= 1'b1;
                    bus.SampleDelayZero <= 1'b1;
                    bus.MemAddr         <= wr_ptr;
                    bus.MemData         <= sat;
                end else begin
                    prime_cnt <= prime_cnt + 1'b1;
                end
            end
            if (bus.Enable && !enable_d)
                prime_cnt <= '0;
        end
    end
endmodule
`default_nettype wire
